// File: rtl/memory_access_arbiter_pkg.sv
// rtl/memory_access_arbiter_pkg.sv - shared state, requester and select-code definitions for the memory arbiter
package memory_access_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int NUM_REQ   = 3;
   localparam int REQ_FETCH = 0;
   localparam int REQ_DATA  = 1;
   localparam int REQ_STACK = 2;

   localparam logic [2:0] DST_PC    = 3'b000;
   localparam logic [2:0] DST_IMM   = 3'b001;
   localparam logic [2:0] DST_SP2   = 3'b100;
   localparam logic [2:0] DST_SPIMM = 3'b101;

   localparam logic [1:0] SRC_MARY    = 2'b00;
   localparam logic [1:0] SRC_SHELLEY = 2'b01;
   localparam logic [1:0] SRC_RA      = 2'b10;

   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      if (oh[2]) return 2'd2;
      if (oh[1]) return 2'd1;
      return 2'd0;
   endfunction

endpackage

// File: rtl/memory_access_arbiter_if.sv
// rtl/memory_access_arbiter_if.sv - requester, memory-select and response bundle between control unit and arbiter
interface memory_access_arbiter_if #(
   parameter int DATA_W = 16
);
   logic [2:0]        req;
   logic [2:0]        req_write;
   logic [8:0]        req_dst;
   logic [5:0]        req_src;
   logic [DATA_W-1:0] mem_out;
   logic              MemWrite;
   logic [1:0]        MemSrc;
   logic [2:0]        MemDst;
   logic [2:0]        gnt;
   logic [2:0]        ack;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   modport master (
      output req, req_write, req_dst, req_src, mem_out,
      input  MemWrite, MemSrc, MemDst, gnt, ack, rdata, busy
   );

   modport slave (
      input  req, req_write, req_dst, req_src, mem_out,
      output MemWrite, MemSrc, MemDst, gnt, ack, rdata, busy
   );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational one-hot winner select; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module mem_arb_pick
   import memory_access_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
   input  logic [1:0] ptr,
`endif
   input  logic [2:0] req,
   output logic [2:0] win
);

`ifdef ARB_ROUND_ROBIN_EN
   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      logic found;
      int   idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win = '0;
      if (req[REQ_DATA])       win[REQ_DATA]  = 1'b1;
      else if (req[REQ_STACK]) win[REQ_STACK] = 1'b1;
      else if (req[REQ_FETCH]) win[REQ_FETCH] = 1'b1;
   end
`endif

endmodule

// File: rtl/memory_access_arbiter.sv
// rtl/memory_access_arbiter.sv - single-port memory arbiter for fetch/data/stack; ARB_ROUND_ROBIN_EN enables round-robin
module memory_access_arbiter
   import memory_access_arbiter_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int MEM_LATENCY = 1
) (
   input logic                    clock,
   input logic                    reset_n,
   memory_access_arbiter_if.slave bus
);

   localparam logic [3:0] LAT_M1 = 4'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic              mem_write_q, mem_write_d;
   logic [1:0]        mem_src_q, mem_src_d;
   logic [2:0]        mem_dst_q, mem_dst_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [2:0]        ack_q, ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              to_done;
   logic [2:0]        win;
   logic [1:0]        win_idx;
`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0]        ptr_q, ptr_d;
`endif

   mem_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
      .ptr (ptr_q),
`endif
      .req (bus.req),
      .win (win)
   );

   assign win_idx = onehot_to_idx(win);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      mem_write_d = 1'b0;
      mem_src_d   = mem_src_q;
      mem_dst_d   = mem_dst_q;
      gnt_d       = gnt_q;
      ack_d       = '0;
      rdata_d     = rdata_q;
      busy_d      = busy_q;
      to_done     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               state_d     = ST_ISSUE;
               wr_d        = |(win & bus.req_write);
               mem_write_d = wr_d;
               mem_src_d   = bus.req_src[win_idx*2 +: 2];
               mem_dst_d   = bus.req_dst[win_idx*3 +: 3];
               gnt_d       = win;
               busy_d      = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (MEM_LATENCY == 0) begin
               to_done = 1'b1;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = LAT_M1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) to_done = 1'b1;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d   = onehot_to_idx(gnt_q);
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      // Read data is sampled while the selects are still held, then they drop.
      if (to_done) begin
         state_d   = ST_DONE;
         ack_d     = gnt_q;
         mem_src_d = '0;
         mem_dst_d = '0;
         if (!wr_q) rdata_d = bus.mem_out;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         mem_write_q <= 1'b0;
         mem_src_q   <= '0;
         mem_dst_q   <= '0;
         gnt_q       <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_q       <= 2'd2;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         mem_write_q <= mem_write_d;
         mem_src_q   <= mem_src_d;
         mem_dst_q   <= mem_dst_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign bus.MemWrite = mem_write_q;
   assign bus.MemSrc   = mem_src_q;
   assign bus.MemDst   = mem_dst_q;
   assign bus.gnt      = gnt_q;
   assign bus.ack      = ack_q;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = busy_q;

endmodule
